nd3_sweep_checker: RTL and testbench

Self-checking stimulus/response stage wrapped around the 3-input NAND (`nd3`) cell. On `start` it drives all eight `{a,b,c}` combinations into the cell's inputs and waits a programmable settle time. It then samples the cell's `y` output and compares it with the expected NAND value, recording pass/fail status, the first failing vector and an error count. It is the clocked, synthesizable counterpart of the directed `nd3` bench and sits directly upstream (drives A/B/C) and downstream (consumes Y) of the cell.

---
 rtl/nd3_sweep_if.sv | 32 +++
 rtl/nd3_sweep_checker.sv | 145 ++++++++++++++
 tb/tb_nd3_sweep_checker.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nd3_sweep_if.sv
// nd3_sweep_if
//   Groups the sweep checker's control, nd3 drive/observe and status signals.
//   master : the checker (drives a/b/c and status, consumes start and y)
//   slave  : the environment (drives start and y, observes the rest)
//   Signals:
//     start      sweep request
//     a, b, c    drive to nd3 inputs A, B, C
//     y          nd3 output Y
//     busy, done, pass, fail, err_vec[2:0], err_count[3:0]  sweep status
interface nd3_sweep_if;
    logic       start;
    logic       a;
    logic       b;
    logic       c;
    logic       y;
    logic       busy;
    logic       done;
    logic       pass;
    logic       fail;
    logic [2:0] err_vec;
    logic [3:0] err_count;

    modport master (
        input  start, y,
        output a, b, c, busy, done, pass, fail, err_vec, err_count
    );

    modport slave (
        output start, y,
        input  a, b, c, busy, done, pass, fail, err_vec, err_count
    );
endinterface

// File: rtl/nd3_sweep_checker.sv
// nd3_sweep_checker
//   Clocked stimulus/response checker for a 3-input NAND cell. On start it
//   steps {a,b,c} through 000..111 (a is MSB), holds each vector for SETTLE
//   cycles, then spends one CHECK cycle and samples y on the edge leaving
//   CHECK against ~(a&b&c). Records pass/fail, first failing vector and a
//   mismatch count.
//   Parameters:
//     SETTLE        cycles each vector is held before sampling (1..15)
//     STOP_ON_FAIL  1: end the sweep on the first mismatch; 0: sweep all eight
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  nd3_sweep_if.master (start/y in; a/b/c and status out)
module nd3_sweep_checker #(
    parameter int unsigned SETTLE       = 2,
    parameter bit          STOP_ON_FAIL = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    nd3_sweep_if.master        bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    // The drive register doubles as the sweep index: vector k is {a,b,c}=k.
    logic [2:0] abc_q,   abc_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;
    logic       pass_q,  pass_d;
    logic       fail_q,  fail_d;
    logic [2:0] ev_q,    ev_d;
    logic [3:0] ec_q,    ec_d;

    logic       exp_y;
    logic       mismatch;

    assign exp_y = ~(&abc_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        abc_d    = abc_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        ev_d     = ev_q;
        ec_d     = ec_q;
        mismatch = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    ev_d    = 3'd0;
                    ec_d    = 4'd0;
                    done_d  = 1'b0;
                    abc_d   = 3'd0;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                    state_d = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_CHECK: begin
                // Case inequality so an X/Z on y in simulation is a mismatch;
                // in hardware this reduces to a plain compare.
                mismatch = (bus.y !== exp_y);
                if (mismatch) begin
                    ec_d   = ec_q + 4'd1;
                    fail_d = 1'b1;
                    if (ec_q == 4'd0) begin
                        ev_d = abc_q;
                    end
                end
                if ((abc_q == 3'd7) || (mismatch && STOP_ON_FAIL)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (ec_d == 4'd0);
                    state_d = S_DONE;
                end else begin
                    // Next vector goes out on the same edge that samples this one.
                    abc_d   = abc_q + 3'd1;
                    cnt_d   = CNT_LOAD;
                    state_d = S_SETTLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            abc_q   <= 3'b111;  // parks the cell at Y=0
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            ev_q    <= 3'd0;
            ec_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            abc_q   <= abc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            ev_q    <= ev_d;
            ec_q    <= ec_d;
        end
    end

    assign bus.a         = abc_q[2];
    assign bus.b         = abc_q[1];
    assign bus.c         = abc_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail      = fail_q;
    assign bus.err_vec   = ev_q;
    assign bus.err_count = ec_q;

endmodule

// File: tb/tb_nd3_sweep_checker.sv
// tb_nd3_sweep_checker
//   Two checkers share clock, reset and the nd3 fault model: u_stop has
//   STOP_ON_FAIL=1, u_full has STOP_ON_FAIL=0. Each sweep pushes the expected
//   completion record for both into a queue; records are popped and compared
//   when the matching done is observed.
module tb_nd3_sweep_checker;

    localparam int SETTLE = 2;
    localparam int VCYC   = SETTLE + 1;
    localparam int BOUND  = 60;

    localparam int M_IDEAL = 0;
    localparam int M_S1    = 1;
    localparam int M_S0    = 2;
    localparam int M_X011  = 3;

    typedef struct {
        int         cyc;
        logic       pass;
        logic       fail;
        logic [2:0] vec;
        logic [3:0] cnt;
    } exp_t;

    typedef struct {
        int   mode;
        exp_t e_stop;
        exp_t e_full;
    } row_t;

    logic clk;
    logic rst;
    int   mode;
    int   n_chk;
    int   n_fail;

    exp_t q_stop[$];
    exp_t q_full[$];
    row_t tbl[4];

    nd3_sweep_if bus_s ();
    nd3_sweep_if bus_f ();

    nd3_sweep_checker #(.SETTLE(SETTLE), .STOP_ON_FAIL(1'b1)) u_stop (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.master)
    );

    nd3_sweep_checker #(.SETTLE(SETTLE), .STOP_ON_FAIL(1'b0)) u_full (
        .clk (clk),
        .rst (rst),
        .bus (bus_f.master)
    );

    function automatic logic ymodel(input int m, input logic [2:0] v);
        case (m)
            M_IDEAL: return ~(&v);
            M_S1:    return 1'b1;
            M_S0:    return 1'b0;
            default: return (v == 3'b011) ? 1'bx : ~(&v);
        endcase
    endfunction

    always_comb bus_s.y = ymodel(mode, {bus_s.a, bus_s.b, bus_s.c});
    always_comb bus_f.y = ymodel(mode, {bus_f.a, bus_f.b, bus_f.c});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic chk_rec(input string who, input int cyc, input exp_t e,
                           input logic p, input logic f, input logic [2:0] v, input logic [3:0] c);
        chk({who, " done cycle"}, 32'(cyc), 32'(e.cyc));
        chk({who, " pass"},       32'(p),   32'(e.pass));
        chk({who, " fail"},       32'(f),   32'(e.fail));
        chk({who, " err_vec"},    32'(v),   32'(e.vec));
        chk({who, " err_count"},  32'(c),   32'(e.cnt));
    endtask

    task automatic chk_reset(input string who, input logic [2:0] abc, input logic bsy,
                             input logic dn, input logic p, input logic f,
                             input logic [2:0] v, input logic [3:0] c);
        chk({who, " rst abc"},       32'(abc), 32'h7);
        chk({who, " rst busy"},      32'(bsy), 32'h0);
        chk({who, " rst done"},      32'(dn),  32'h0);
        chk({who, " rst pass"},      32'(p),   32'h0);
        chk({who, " rst fail"},      32'(f),   32'h0);
        chk({who, " rst err_vec"},   32'(v),   32'h0);
        chk({who, " rst err_count"}, 32'(c),   32'h0);
    endtask

    task automatic reset_check();
        chk_reset("stop", {bus_s.a, bus_s.b, bus_s.c}, bus_s.busy, bus_s.done,
                  bus_s.pass, bus_s.fail, bus_s.err_vec, bus_s.err_count);
        chk_reset("full", {bus_f.a, bus_f.b, bus_f.c}, bus_f.busy, bus_f.done,
                  bus_f.pass, bus_f.fail, bus_f.err_vec, bus_f.err_count);
    endtask

    // Pulse start for one edge; expectations enter the scoreboard here.
    task automatic launch(input exp_t es, input exp_t ef);
        q_stop.push_back(es);
        q_full.push_back(ef);
        bus_s.start = 1'b1;
        bus_f.start = 1'b1;
        tick();
        bus_s.start = 1'b0;
        bus_f.start = 1'b0;
    endtask

    // Run until both checkers report done. extra_at re-pulses start before
    // that edge number (should be ignored while busy).
    task automatic collect(input bit traj, input int extra_at);
        bit   got_s;
        bit   got_f;
        exp_t e;
        got_s = 1'b0;
        got_f = 1'b0;
        for (int k = 1; k <= BOUND && !(got_s && got_f); k++) begin
            bus_s.start = (k == extra_at);
            bus_f.start = (k == extra_at);
            tick();
            if (traj && k < 8 * VCYC) begin
                chk("abc step", 32'({bus_f.a, bus_f.b, bus_f.c}), 32'(k / VCYC));
            end
            if (!got_s && bus_s.done) begin
                got_s = 1'b1;
                e = q_stop.pop_front();
                chk_rec("stop", k, e, bus_s.pass, bus_s.fail, bus_s.err_vec, bus_s.err_count);
                chk("stop busy at done", 32'(bus_s.busy), 32'h0);
            end
            if (!got_f && bus_f.done) begin
                got_f = 1'b1;
                e = q_full.pop_front();
                chk_rec("full", k, e, bus_f.pass, bus_f.fail, bus_f.err_vec, bus_f.err_count);
                chk("full busy at done", 32'(bus_f.busy), 32'h0);
            end
        end
        bus_s.start = 1'b0;
        bus_f.start = 1'b0;
        if (!got_s) begin
            n_chk++; n_fail++;
            $display("FAIL stop done timeout: got none expected done within %0d", BOUND);
            void'(q_stop.pop_front());
        end
        if (!got_f) begin
            n_chk++; n_fail++;
            $display("FAIL full done timeout: got none expected done within %0d", BOUND);
            void'(q_full.pop_front());
        end
    endtask

    exp_t e_ok;
    exp_t e_s0_stop;
    exp_t e_s0_full;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        mode   = M_IDEAL;

        //                mode     stop: cyc pass fail vec cnt      full: cyc pass fail vec cnt
        tbl[0] = '{M_IDEAL, '{24, 1'b1, 1'b0, 3'd0, 4'd0}, '{24, 1'b1, 1'b0, 3'd0, 4'd0}};
        tbl[1] = '{M_S1,    '{24, 1'b0, 1'b1, 3'd7, 4'd1}, '{24, 1'b0, 1'b1, 3'd7, 4'd1}};
        tbl[2] = '{M_S0,    '{ 3, 1'b0, 1'b1, 3'd0, 4'd1}, '{24, 1'b0, 1'b1, 3'd0, 4'd7}};
        tbl[3] = '{M_X011,  '{12, 1'b0, 1'b1, 3'd3, 4'd1}, '{24, 1'b0, 1'b1, 3'd3, 4'd1}};
        e_ok      = tbl[0].e_stop;
        e_s0_stop = tbl[2].e_stop;
        e_s0_full = tbl[2].e_full;

        bus_s.start = 1'b0;
        bus_f.start = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        reset_check();
        rst = 1'b0;
        tick();

        // Main sweeps, one per fault model; DONE+start starts the next one.
        for (int r = 0; r < 4; r++) begin
            mode = tbl[r].mode;
            launch(tbl[r].e_stop, tbl[r].e_full);
            chk("abc after accept", 32'({bus_f.a, bus_f.b, bus_f.c}), 32'h0);
            chk("busy after accept", 32'(bus_f.busy), 32'h1);
            collect(r == 0, 0);
        end

        // Start while busy is ignored.
        mode = M_IDEAL;
        launch(e_ok, e_ok);
        collect(1'b0, 10);

        // Reset mid-sweep: fail already set on the full-sweep checker.
        mode = M_S0;
        bus_s.start = 1'b1;
        bus_f.start = 1'b1;
        tick();
        bus_s.start = 1'b0;
        bus_f.start = 1'b0;
        for (int k = 1; k <= 12; k++) tick();
        chk("mid busy",      32'(bus_f.busy),      32'h1);
        chk("mid fail",      32'(bus_f.fail),      32'h1);
        chk("mid err_count", 32'(bus_f.err_count), 32'h4);
        chk("mid done",      32'(bus_f.done),      32'h0);
        rst = 1'b1;
        #1;
        reset_check();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("idle busy", 32'(bus_f.busy), 32'h0);
        chk("idle abc",  32'({bus_f.a, bus_f.b, bus_f.c}), 32'h7);

        // Failing sweep, then restart from DONE with a good cell.
        launch(e_s0_stop, e_s0_full);
        collect(1'b0, 0);
        mode = M_IDEAL;
        launch(e_ok, e_ok);
        chk("restart fail",      32'(bus_f.fail),      32'h0);
        chk("restart err_count", 32'(bus_f.err_count), 32'h0);
        chk("restart err_vec",   32'(bus_f.err_vec),   32'h0);
        chk("restart done",      32'(bus_f.done),      32'h0);
        chk("restart busy",      32'(bus_s.busy),      32'h1);
        chk("restart stop fail", 32'(bus_s.fail),      32'h0);
        collect(1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
